// File: rtl/mem_rd_port_arbiter_if.sv
// Requester/memory bundle for mem_rd_port_arbiter; statistics signals appear when MEM_RD_ARB_STATS_EN is defined.
interface mem_rd_port_arbiter_if #(
  parameter int unsigned NUM_REQ    = 3,
  parameter int unsigned ADDR_WIDTH = 6,
  parameter int unsigned DATA_WIDTH = 32
);
  logic [NUM_REQ-1:0]            req;
  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr;
  logic [NUM_REQ-1:0]            gnt;
  logic [ADDR_WIDTH-1:0]         mem_addr;
  logic                          mem_rd_en;
  logic [DATA_WIDTH-1:0]         mem_rd_data;
  logic [NUM_REQ-1:0]            rsp_valid;
  logic [DATA_WIDTH-1:0]         rsp_data;
  logic                          busy;
`ifdef MEM_RD_ARB_STATS_EN
  logic [15:0]                   conflict_cnt;
  logic [NUM_REQ*16-1:0]         grant_cnt;

  modport slave (
    input  req, req_addr, mem_rd_data,
    output gnt, mem_addr, mem_rd_en, rsp_valid, rsp_data, busy, conflict_cnt, grant_cnt
  );
  modport master (
    output req, req_addr, mem_rd_data,
    input  gnt, mem_addr, mem_rd_en, rsp_valid, rsp_data, busy, conflict_cnt, grant_cnt
  );
`else
  modport slave (
    input  req, req_addr, mem_rd_data,
    output gnt, mem_addr, mem_rd_en, rsp_valid, rsp_data, busy
  );
  modport master (
    output req, req_addr, mem_rd_data,
    input  gnt, mem_addr, mem_rd_en, rsp_valid, rsp_data, busy
  );
`endif
endinterface

// File: rtl/mem_rd_port_arbiter.sv
// Round-robin arbiter sharing one fixed-latency memory read port among NUM_REQ requesters.
// Optional statistics counters are enabled with `define MEM_RD_ARB_STATS_EN.
module mem_rd_port_arbiter #(
  parameter int unsigned NUM_REQ    = 3,
  parameter int unsigned ADDR_WIDTH = 6,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned RD_LATENCY = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  mem_rd_port_arbiter_if.slave  bus
);

  localparam int unsigned PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int unsigned CNT_W = 16;

  if (NUM_REQ < 2 || NUM_REQ > 8) begin : g_bad_num_req
    $error("mem_rd_port_arbiter: NUM_REQ must be 2..8");
  end
  if (RD_LATENCY < 1 || RD_LATENCY > 4) begin : g_bad_latency
    $error("mem_rd_port_arbiter: RD_LATENCY must be 1..4");
  end

  logic [PTR_W-1:0]                     rr_ptr_q, rr_ptr_d;
  logic [PTR_W-1:0]                     idx;
  logic                                 found;
  logic [NUM_REQ-1:0]                   gnt_c;
  logic [ADDR_WIDTH-1:0]                mem_addr_c;
  logic [RD_LATENCY-1:0][NUM_REQ-1:0]   tag_pipe_q;

  // Search from rr_ptr with wrap; grant suppressed while in reset.
  always_comb begin
    gnt_c    = '0;
    rr_ptr_d = rr_ptr_q;
    found    = 1'b0;
    idx      = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      idx = PTR_W'((32'(rr_ptr_q) + i) % NUM_REQ);
      if (!found && rst_n && bus.req[idx]) begin
        found      = 1'b1;
        gnt_c[idx] = 1'b1;
        rr_ptr_d   = (idx == PTR_W'(NUM_REQ - 1)) ? '0 : idx + PTR_W'(1);
      end
    end
  end

  // Address mux driven by the one-hot grant, zero when idle.
  always_comb begin
    mem_addr_c = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (gnt_c[i]) begin
        mem_addr_c = bus.req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr_q   <= '0;
      tag_pipe_q <= '0;
    end else begin
      rr_ptr_q      <= rr_ptr_d;
      tag_pipe_q[0] <= gnt_c;
      for (int unsigned j = 1; j < RD_LATENCY; j++) begin
        tag_pipe_q[j] <= tag_pipe_q[j-1];
      end
    end
  end

  assign bus.gnt       = gnt_c;
  assign bus.mem_rd_en = |gnt_c;
  assign bus.mem_addr  = mem_addr_c;
  assign bus.rsp_valid = tag_pipe_q[RD_LATENCY-1];
  assign bus.rsp_data  = bus.mem_rd_data;
  assign bus.busy      = |tag_pipe_q;

`ifdef MEM_RD_ARB_STATS_EN
  logic [CNT_W-1:0]              conflict_cnt_q;
  logic [NUM_REQ-1:0][CNT_W-1:0] grant_cnt_q;
  logic                          multi_req_c;

  // More than one bit set: clearing the lowest set bit leaves something.
  assign multi_req_c = |(bus.req & (bus.req - NUM_REQ'(1)));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      conflict_cnt_q <= '0;
      grant_cnt_q    <= '0;
    end else begin
      if (multi_req_c && (conflict_cnt_q != {CNT_W{1'b1}})) begin
        conflict_cnt_q <= conflict_cnt_q + CNT_W'(1);
      end
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
        if (gnt_c[i] && (grant_cnt_q[i] != {CNT_W{1'b1}})) begin
          grant_cnt_q[i] <= grant_cnt_q[i] + CNT_W'(1);
        end
      end
    end
  end

  assign bus.conflict_cnt = conflict_cnt_q;
  assign bus.grant_cnt    = grant_cnt_q;
`endif

endmodule

// File: tb/tb_mem_rd_port_arbiter.sv
// Directed bench for mem_rd_port_arbiter at read latencies 1, 2 and 3.
module tb_mem_rd_port_arbiter;

  localparam int unsigned NR = 3;
  localparam int unsigned AW = 6;
  localparam int unsigned DW = 32;

  logic clk;
  logic rst_n;
  int   n_cmp;
  int   n_err;

  mem_rd_port_arbiter_if #(.NUM_REQ(NR), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) if1 ();
  mem_rd_port_arbiter_if #(.NUM_REQ(NR), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) if2 ();
  mem_rd_port_arbiter_if #(.NUM_REQ(NR), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) if3 ();

  mem_rd_port_arbiter #(.NUM_REQ(NR), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .RD_LATENCY(1)) u_lat1 (
    .clk(clk), .rst_n(rst_n), .bus(if1));
  mem_rd_port_arbiter #(.NUM_REQ(NR), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .RD_LATENCY(2)) u_lat2 (
    .clk(clk), .rst_n(rst_n), .bus(if2));
  mem_rd_port_arbiter #(.NUM_REQ(NR), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .RD_LATENCY(3)) u_lat3 (
    .clk(clk), .rst_n(rst_n), .bus(if3));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [DW-1:0] mem_word(input logic [AW-1:0] a);
    return {16'hC0DE, 10'h000, a};
  endfunction

  // Memory models with matching read latency
  logic [DW-1:0]       m1_q;
  logic [1:0][DW-1:0]  m2_q;
  logic [2:0][DW-1:0]  m3_q;
  always @(posedge clk) begin
    m1_q <= if1.mem_rd_en ? mem_word(if1.mem_addr) : '0;
    m2_q <= {m2_q[0], (if2.mem_rd_en ? mem_word(if2.mem_addr) : 32'h0)};
    m3_q <= {m3_q[1:0], (if3.mem_rd_en ? mem_word(if3.mem_addr) : 32'h0)};
  end
  assign if1.mem_rd_data = m1_q;
  assign if2.mem_rd_data = m2_q[1];
  assign if3.mem_rd_data = m3_q[2];

  task automatic pulse_reset();
    @(negedge clk);
    if1.req = '0; if2.req = '0; if3.req = '0;
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    if1.req = 3'b111; if1.req_addr = {6'd3, 6'd2, 6'd1};
    @(negedge clk); #1;
    n_cmp++; if (if1.gnt !== 3'b000) begin n_err++; $display("FAIL reset_gnt: got %b want 000", if1.gnt); end
    n_cmp++; if (if1.mem_rd_en !== 1'b0) begin n_err++; $display("FAIL reset_rd_en: got %b want 0", if1.mem_rd_en); end
    n_cmp++; if (if1.mem_addr !== 6'd0) begin n_err++; $display("FAIL reset_addr: got %0d want 0", if1.mem_addr); end
    n_cmp++; if (if1.rsp_valid !== 3'b000) begin n_err++; $display("FAIL reset_rsp_valid: got %b want 000", if1.rsp_valid); end
    n_cmp++; if (if3.busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b want 0", if3.busy); end
    if1.req = '0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_single();
    @(negedge clk);
    if1.req = 3'b010; if1.req_addr = {6'd9, 6'd5, 6'd7};
    #1;
    n_cmp++; if (if1.gnt !== 3'b010) begin n_err++; $display("FAIL single_gnt: got %b want 010", if1.gnt); end
    n_cmp++; if (if1.mem_rd_en !== 1'b1) begin n_err++; $display("FAIL single_rd_en: got %b want 1", if1.mem_rd_en); end
    n_cmp++; if (if1.mem_addr !== 6'd5) begin n_err++; $display("FAIL single_addr: got %0d want 5", if1.mem_addr); end
    @(negedge clk);
    if1.req = '0;
    #1;
    n_cmp++; if (if1.rsp_valid !== 3'b010) begin n_err++; $display("FAIL single_rsp_valid: got %b want 010", if1.rsp_valid); end
    n_cmp++; if (if1.rsp_data !== mem_word(6'd5)) begin n_err++; $display("FAIL single_rsp_data: got %h want %h", if1.rsp_data, mem_word(6'd5)); end
    n_cmp++; if (if1.busy !== 1'b1) begin n_err++; $display("FAIL single_busy: got %b want 1", if1.busy); end
    n_cmp++; if (if1.mem_addr !== 6'd0) begin n_err++; $display("FAIL single_idle_addr: got %0d want 0", if1.mem_addr); end
  endtask

  // Pointer sits at 2 after granting requester 1
  task automatic test_wrap_skip();
    @(negedge clk);
    if1.req = 3'b011; if1.req_addr = {6'd20, 6'd11, 6'd10};
    #1;
    n_cmp++; if (if1.gnt !== 3'b001) begin n_err++; $display("FAIL wrap_gnt0: got %b want 001", if1.gnt); end
    n_cmp++; if (if1.mem_addr !== 6'd10) begin n_err++; $display("FAIL wrap_addr0: got %0d want 10", if1.mem_addr); end
    @(negedge clk); #1;
    n_cmp++; if (if1.gnt !== 3'b010) begin n_err++; $display("FAIL wrap_gnt1: got %b want 010", if1.gnt); end
    n_cmp++; if (if1.rsp_valid !== 3'b001) begin n_err++; $display("FAIL wrap_rsp0: got %b want 001", if1.rsp_valid); end
    n_cmp++; if (if1.rsp_data !== mem_word(6'd10)) begin n_err++; $display("FAIL wrap_data0: got %h want %h", if1.rsp_data, mem_word(6'd10)); end
    @(negedge clk);
    if1.req = '0;
    #1;
    n_cmp++; if (if1.rsp_valid !== 3'b010) begin n_err++; $display("FAIL wrap_rsp1: got %b want 010", if1.rsp_valid); end
    n_cmp++; if (if1.rsp_data !== mem_word(6'd11)) begin n_err++; $display("FAIL wrap_data1: got %h want %h", if1.rsp_data, mem_word(6'd11)); end
  endtask

  task automatic test_full_contention();
    logic [2:0] exp_g;
    logic [2:0] prev_g;
    logic [5:0] exp_a;
    pulse_reset();
    exp_g  = 3'b001;
    prev_g = 3'b000;
    exp_a  = 6'd30;
    if1.req_addr = {6'd32, 6'd31, 6'd30};
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if1.req = 3'b111;
      #1;
      n_cmp++; if (if1.gnt !== exp_g) begin n_err++; $display("FAIL contention_gnt[%0d]: got %b want %b", c, if1.gnt, exp_g); end
      n_cmp++; if (if1.mem_addr !== exp_a) begin n_err++; $display("FAIL contention_addr[%0d]: got %0d want %0d", c, if1.mem_addr, exp_a); end
      n_cmp++; if (if1.rsp_valid !== prev_g) begin n_err++; $display("FAIL contention_rsp[%0d]: got %b want %b", c, if1.rsp_valid, prev_g); end
      prev_g = exp_g;
      exp_g  = {exp_g[1:0], exp_g[2]};
      exp_a  = (exp_a == 6'd32) ? 6'd30 : exp_a + 6'd1;
    end
    @(negedge clk);
    if1.req = '0;
    #1;
    n_cmp++; if (if1.rsp_valid !== 3'b100) begin n_err++; $display("FAIL contention_rsp_last: got %b want 100", if1.rsp_valid); end
    n_cmp++; if (if1.rsp_data !== mem_word(6'd32)) begin n_err++; $display("FAIL contention_data_last: got %h want %h", if1.rsp_data, mem_word(6'd32)); end
  endtask

  // Pointer at 0: lone requester repeats, then yields to a newcomer
  task automatic test_back_to_back();
    logic [2:0] exp_g [5];
    logic [2:0] stim  [5];
    stim  = '{3'b001, 3'b001, 3'b001, 3'b101, 3'b101};
    exp_g = '{3'b001, 3'b001, 3'b001, 3'b100, 3'b001};
    if1.req_addr = {6'd42, 6'd41, 6'd40};
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      if1.req = stim[c];
      #1;
      n_cmp++; if (if1.gnt !== exp_g[c]) begin n_err++; $display("FAIL b2b_gnt[%0d]: got %b want %b", c, if1.gnt, exp_g[c]); end
    end
    @(negedge clk);
    if1.req = '0;
  endtask

  task automatic test_latency3();
    logic [2:0] exp_v;
    logic       exp_b;
    if3.req_addr = {6'd19, 6'd18, 6'd17};
    @(negedge clk);
    if3.req = 3'b001;
    #1;
    n_cmp++; if (if3.gnt !== 3'b001) begin n_err++; $display("FAIL lat3_gnt: got %b want 001", if3.gnt); end
    n_cmp++; if (if3.busy !== 1'b0) begin n_err++; $display("FAIL lat3_busy_t0: got %b want 0", if3.busy); end
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      if3.req = '0;
      #1;
      exp_v = (k == 3) ? 3'b001 : 3'b000;
      exp_b = (k <= 3);
      n_cmp++; if (if3.rsp_valid !== exp_v) begin n_err++; $display("FAIL lat3_rsp[t+%0d]: got %b want %b", k, if3.rsp_valid, exp_v); end
      n_cmp++; if (if3.busy !== exp_b) begin n_err++; $display("FAIL lat3_busy[t+%0d]: got %b want %b", k, if3.busy, exp_b); end
      if (k == 3) begin
        n_cmp++; if (if3.rsp_data !== mem_word(6'd17)) begin n_err++; $display("FAIL lat3_data: got %h want %h", if3.rsp_data, mem_word(6'd17)); end
      end
    end
  endtask

  task automatic test_reset_midflight();
    if2.req_addr = {6'd34, 6'd33, 6'd32};
    @(negedge clk);
    if2.req = 3'b010;
    #1;
    n_cmp++; if (if2.gnt !== 3'b010) begin n_err++; $display("FAIL midrst_gnt: got %b want 010", if2.gnt); end
    @(negedge clk);
    if2.req = '0;
    #1;
    n_cmp++; if (if2.busy !== 1'b1) begin n_err++; $display("FAIL midrst_busy_pre: got %b want 1", if2.busy); end
    rst_n = 1'b0;
    #1;
    n_cmp++; if (if2.busy !== 1'b0) begin n_err++; $display("FAIL midrst_busy_async: got %b want 0", if2.busy); end
    n_cmp++; if (if2.rsp_valid !== 3'b000) begin n_err++; $display("FAIL midrst_rsp_async: got %b want 000", if2.rsp_valid); end
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk); #1;
      n_cmp++; if (if2.rsp_valid !== 3'b000) begin n_err++; $display("FAIL midrst_no_rsp[%0d]: got %b want 000", k, if2.rsp_valid); end
    end
    @(negedge clk);
    if2.req = 3'b111;
    #1;
    n_cmp++; if (if2.gnt !== 3'b001) begin n_err++; $display("FAIL midrst_first_gnt: got %b want 001", if2.gnt); end
    @(negedge clk);
    if2.req = '0;
  endtask

`ifdef MEM_RD_ARB_STATS_EN
  task automatic test_stats();
    pulse_reset();
    if1.req_addr = {6'd2, 6'd1, 6'd0};
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if1.req = (c < 4) ? 3'b111 : 3'b001;
    end
    @(negedge clk);
    if1.req = '0;
    #1;
    n_cmp++; if (if1.conflict_cnt !== 16'd4) begin n_err++; $display("FAIL stats_conflict: got %0d want 4", if1.conflict_cnt); end
    n_cmp++; if (if1.grant_cnt[15:0] !== 16'd4) begin n_err++; $display("FAIL stats_grant0: got %0d want 4", if1.grant_cnt[15:0]); end
    n_cmp++; if (if1.grant_cnt[31:16] !== 16'd1) begin n_err++; $display("FAIL stats_grant1: got %0d want 1", if1.grant_cnt[31:16]); end
    n_cmp++; if (if1.grant_cnt[47:32] !== 16'd1) begin n_err++; $display("FAIL stats_grant2: got %0d want 1", if1.grant_cnt[47:32]); end
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    n_cmp = 0;
    n_err = 0;
    rst_n = 1'b0;
    if1.req = '0; if1.req_addr = '0;
    if2.req = '0; if2.req_addr = '0;
    if3.req = '0; if3.req_addr = '0;
    test_reset();
    test_single();
    test_wrap_skip();
    test_full_contention();
    test_back_to_back();
    test_latency3();
    test_reset_midflight();
`ifdef MEM_RD_ARB_STATS_EN
    test_stats();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
